// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the data-memory port: one request at a time,
// misaligned accesses split into two word-aligned beats, extended load data.
module lsu_mem_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [BE_WIDTH-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_accept;
    logic                  w_illegal;
    logic [1:0]            w_off;
    logic [4:0]            w_sh0;
    logic [5:0]            w_sh1;
    logic [BE_WIDTH-1:0]   w_size_mask;
    logic [7:0]            w_mask;
    logic                  w_split;
    logic [DATA_WIDTH-1:0] w_addr0;
    logic [DATA_WIDTH-1:0] w_addr1;
    logic [DATA_WIDTH-1:0] w_wdata0;
    logic [DATA_WIDTH-1:0] w_wdata1;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_illegal = 1'b0;
        unique case (req_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = req_we;
            default:                w_illegal = 1'b0;
        endcase
    end

    // Lane geometry of the captured request
    assign w_off = r_addr[1:0];
    assign w_sh0 = {w_off, 3'b000};
    assign w_sh1 = 6'd32 - {1'b0, w_off, 3'b000};

    always_comb begin
        unique case (r_f3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    assign w_mask   = 8'({4'b0000, w_size_mask} << w_off);
    assign w_split  = |w_mask[7:4];
    assign w_addr0  = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign w_addr1  = w_addr0 + 32'd4;
    assign w_wdata0 = r_wdata << w_sh0;
    assign w_wdata1 = r_wdata >> w_sh1;

    // rdata1 is cleared at accept, so unsplit loads shift in zeros
    assign w_raw = 32'({r_rdata1, r_rdata0} >> w_sh0);

    always_comb begin
        unique case (r_f3)
            3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b100:  w_ext = {24'd0, w_raw[7:0]};
            3'b101:  w_ext = {16'd0, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_f3     <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_f3     <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rdata0 <= '0;
                r_rdata1 <= '0;
            end
            if (r_state == S_WAIT0 && mem_rvalid) begin
                r_rdata0 <= mem_rdata;
            end
            if (r_state == S_WAIT1 && mem_rvalid) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_illegal ? S_ERR : S_REQ0;
                end
            end
            S_REQ0: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_addr0;
                mem_be    = w_mask[3:0];
                mem_wdata = w_wdata0;
                if (mem_gnt) begin
                    if (!r_we) begin
                        w_next = S_WAIT0;
                    end else begin
                        w_next = w_split ? S_REQ1 : S_RESP;
                    end
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    w_next = w_split ? S_REQ1 : S_RESP;
                end
            end
            S_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_addr1;
                mem_be    = w_mask[7:4];
                mem_wdata = w_wdata1;
                if (mem_gnt) begin
                    w_next = r_we ? S_RESP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_we ? '0 : w_ext;
                w_next     = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-level memory model, randomized
// memory responder and a response scoreboard fed at request accept.
`timescale 1ns/1ps
module tb_lsu_mem_initiator;

    typedef struct {
        bit [31:0] addr;
        bit [3:0]  be;
        bit        we;
        bit [31:0] wdata;
    } beat_t;

    typedef struct {
        bit        err;
        bit [31:0] rdata;
        int        acc;
        int        lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int gfix   = -1;
    int rfix   = -1;
    bit no_rv  = 1'b0;
    bit noise  = 1'b1;

    beat_t bq[$];
    resp_t rq[$];
    logic [7:0] mb [bit [31:0]];
    logic [7:0] rm [bit [31:0]];

    lsu_mem_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(bit [31:0] a);
        bit [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[7:0];
    endfunction

    function automatic logic [7:0] mbyte(bit [31:0] a);
        return mb.exists(a) ? mb[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rbyte(bit [31:0] a);
        return rm.exists(a) ? rm[a] : init_byte(a);
    endfunction

    function automatic bit [31:0] lanes(bit [3:0] be);
        bit [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic preload(bit [31:0] wa, bit [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mb[wa + i] = w[8*i +: 8];
            rm[wa + i] = w[8*i +: 8];
        end
    endtask

    // Reference: byte-wise access, grouped into words as they appear
    task automatic issue(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                         bit use_exp, bit exp_err, bit [31:0] exp_rd, int lat);
        int        n;
        int        g;
        bit        ill;
        bit        have;
        beat_t     cur;
        resp_t     r;
        bit [31:0] ba;
        bit [31:0] v;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        v   = 0;
        if (!ill) begin
            have = 1'b0;
            cur  = '{32'd0, 4'd0, we, 32'd0};
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                if (!have || {ba[31:2], 2'b00} != cur.addr) begin
                    if (have) bq.push_back(cur);
                    cur  = '{{ba[31:2], 2'b00}, 4'd0, we, 32'd0};
                    have = 1'b1;
                end
                cur.be[ba[1:0]] = 1'b1;
                cur.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
                if (we) mb[ba] = wd[8*i +: 8];
                else v[8*i +: 8] = mbyte(ba);
            end
            bq.push_back(cur);
            if (!we && !f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!we && !f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        r.err   = use_exp ? exp_err : ill;
        r.rdata = use_exp ? exp_rd : ((ill || we) ? 32'd0 : v);
        r.acc   = cyc;
        r.lat   = lat;
        rq.push_back(r);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((rq.size() != 0 || bq.size() != 0 || !req_ready) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("idle_timeout", rq.size() + bq.size(), 0);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (rq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got err=%b rdata=%h expected none",
                         resp_err, resp_rdata);
            end else begin
                resp_t e;
                e = rq.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                if (e.lat > 0) chk("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Memory responder
    initial begin
        beat_t e;
        beat_t s;
        int    d;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rst) continue;
            if (!mem_req) begin
                if (noise && $urandom_range(0, 7) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
                continue;
            end
            s = '{mem_addr, mem_be, mem_we, mem_wdata};
            if (bq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr=%h be=%b expected none",
                         mem_addr, mem_be);
            end else begin
                e = bq.pop_front();
                chk("beat_addr", s.addr, e.addr);
                chk("beat_be", {28'd0, s.be}, {28'd0, e.be});
                chk("beat_we", {31'd0, s.we}, {31'd0, e.we});
                if (e.we) chk("beat_wdata", s.wdata & lanes(s.be), e.wdata);
            end
            d = (gfix >= 0) ? gfix : $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                chk("hold_req", {31'd0, mem_req}, 32'd1);
                chk("hold_addr", mem_addr, s.addr);
                chk("hold_be", {28'd0, mem_be}, {28'd0, s.be});
                chk("hold_wdata", mem_wdata, s.wdata);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (s.we) begin
                for (int i = 0; i < 4; i++)
                    if (s.be[i]) rm[s.addr + i] = s.wdata[8*i +: 8];
                continue;
            end
            if (no_rv) continue;
            d = (rfix >= 1) ? rfix : $urandom_range(1, 3);
            for (int k = 1; k < d; k++) @(negedge clk);
            mem_rvalid = 1'b1;
            for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = rbyte(s.addr + i);
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    end

    initial begin
        resp_t     dropped;
        bit [31:0] a;
        int        g;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        gfix = 0;
        rfix = 1;
        preload(32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF, 3);
        wait_idle();
        issue(1'b1, 3'b010, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'd0, 2);
        wait_idle();
        preload(32'h100, 32'h80123456);
        issue(1'b0, 3'b000, 32'h103, 32'd0, 1'b1, 1'b0, 32'hFFFFFF80, 0);
        issue(1'b0, 3'b100, 32'h103, 32'd0, 1'b1, 1'b0, 32'h00000080, 0);
        issue(1'b1, 3'b001, 32'h103, 32'h0000ABCD, 1'b1, 1'b0, 32'd0, 0);
        wait_idle();
        preload(32'h200, 32'h44331122);
        preload(32'h204, 32'h77886655);
        gfix = 3;
        issue(1'b0, 3'b010, 32'h202, 32'd0, 1'b1, 1'b0, 32'h66554433, 0);
        wait_idle();
        gfix = 0;
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0, 0);
        issue(1'b0, 3'b011, 32'h100, 32'd0, 1'b1, 1'b1, 32'd0, 0);
        issue(1'b1, 3'b100, 32'h100, 32'd0, 1'b1, 1'b1, 32'd0, 0);
        wait_idle();

        // Reset while the load sits in WAIT0: no response may follow
        no_rv = 1'b1;
        noise = 1'b0;
        issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0, 0);
        dropped = rq.pop_back();
        g = 0;
        while (bq.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("rst_test_beat_seen", bq.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        no_rv = 1'b0;
        noise = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0, 3);
        wait_idle();

        gfix = -1;
        rfix = -1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 + $urandom_range(0, 15);
            else a = 32'h100 + $urandom_range(0, 63);
            issue(1'($urandom), 3'($urandom), a, $urandom, 1'b0, 1'b0, 32'd0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the pipeline side of the data-memory port. It is the initiator; data memory is the responder.
- Takes one load/store request at a time from the execute/memory stage.
- Drives a word-aligned memory bus with byte-lane enables, and splits misaligned accesses into two aligned beats.
- Returns sign- or zero-extended load data with a single-cycle response pulse.

Parameters:
- DATA_WIDTH, 32: data and address width; only 32 is supported.
- BE_WIDTH, 4: byte-lane count, equal to DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; illegal funct3.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rvalid  in  1  read data valid; at least one cycle after the read grant.
- mem_rdata  in  32  read data.

Behaviour:
- Reset: state=IDLE. resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_be and mem_wdata are all 0. req_ready=1. A mid-transaction reset drops mem_req immediately, with no completion pulse.
- Sizes and lane masks: size mask B=0001, H=0011, W=1111. off=addr[1:0]. Shifted mask m = size_mask << off, 8 bits wide.
- Beat 0: mem_be=m[3:0], mem_addr={addr[31:2],2'b00}, mem_wdata=wdata<<(8*off).
- Split: an access needs beat 1 when m[7:4] != 0, i.e. H at off=3 or W at off 1..3.
- Beat 1: mem_be=m[7:4], mem_addr=beat0+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x0), mem_wdata=wdata>>(8*(4-off)).
- Request capture: all request fields are captured at accept; later pipeline-side input changes are ignored.
- States:
  - IDLE: on accept, go to ERR if funct3 is illegal (011, 110, 111, or 100/101 with we=1); otherwise go to REQ0.
  - REQ0: mem_req=1, bus fields stable until mem_gnt. On gnt: a load goes to WAIT0; a store goes to REQ1 if split, else RESP.
  - WAIT0: on mem_rvalid, capture rdata0; go to REQ1 if split, else RESP.
  - REQ1 and WAIT1: same as REQ0 and WAIT0 for beat 1, capturing rdata1; then RESP.
  - RESP: resp_valid=1 for one cycle; return to IDLE.
  - ERR: resp_valid=1 and resp_err=1 for one cycle, with no memory traffic; return to IDLE.
- Handshake rules:
  - mem_req deasserts in the cycle after gnt unless the next state is REQ1.
  - Stores complete on grant; no rvalid is expected.
  - mem_rvalid outside WAIT0/WAIT1 is ignored.
- Load assembly: raw = ({rdata1, rdata0} >> (8*off))[31:0], where rdata1=0 if not split. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Latency: aligned load with gnt in the REQ0 cycle and rvalid the next cycle: accept at t0, mem_req at t1, rvalid at t2, resp_valid at t3. Aligned store: resp_valid at t2.
- Between requests: req_ready is 0 from the cycle after accept until IDLE is re-entered. Back-to-back requests leave one IDLE cycle between them.

Test Plan:
- Aligned LW, addr=0x100, mem returns 0xDEADBEEF, gnt immediate, rvalid +1 -> mem_addr=0x100, be=1111; resp_rdata=0xDEADBEEF at t3.
- LB addr=0x103, rdata=0x80xxxxxx -> be=1000, resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr=0x103, wdata=0x0000ABCD -> beat0 addr 0x100, be=1000, wdata=0xCD000000; beat1 addr 0x104, be=0001, wdata=0x000000AB; one resp_valid.
- LW addr=0x202, rdata0=0x4433xxxx, rdata1=0xxxxx6655 -> resp_rdata=0x66554433. Test with gnt delayed 3 cycles; mem_addr/mem_be must stay stable while waiting.
- Wrap: SW addr=0xFFFFFFFE -> beat1 mem_addr=0x00000000, be=0011.
- Error and reset: funct3=011 -> resp_err=1 with no mem_req. Assert rst during WAIT0 -> mem_req=0, req_ready=1, no resp_valid; the next LW completes normally.
